mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 12 +
 rtl/mem_wb_register.sv | 50 +++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths and FSM state encoding for the memory pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W_DEF = 22;
    localparam int unsigned REG_W_DEF  = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: loads on enable, bubble load zeroes every field.
module mem_wb_register #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              bubble,
    input  logic [DATA_W-1:0] read_data_d,
    input  logic [DATA_W-1:0] alu_result_d,
    input  logic [REG_W-1:0]  write_register_d,
    input  logic              mem_reg_d,
    input  logic              reg_write_d,
    output logic [DATA_W-1:0] read_data_q,
    output logic [DATA_W-1:0] alu_result_q,
    output logic [REG_W-1:0]  write_register_q,
    output logic              mem_reg_q,
    output logic              reg_write_q,
    output logic              valid_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q      <= '0;
            alu_result_q     <= '0;
            write_register_q <= '0;
            mem_reg_q        <= 1'b0;
            reg_write_q      <= 1'b0;
            valid_q          <= 1'b0;
        end else if (load_en) begin
            if (bubble) begin
                read_data_q      <= '0;
                alu_result_q     <= '0;
                write_register_q <= '0;
                mem_reg_q        <= 1'b0;
                reg_write_q      <= 1'b0;
                valid_q          <= 1'b0;
            end else begin
                read_data_q      <= read_data_d;
                alu_result_q     <= alu_result_d;
                write_register_q <= write_register_d;
                mem_reg_q        <= mem_reg_d;
                reg_write_q      <= reg_write_d;
                valid_q          <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU ops straight to MEM/WB, or issues one data-memory
// request and stalls upstream until it is acknowledged.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_mem_in,
    input  logic [DATA_W-1:0] alu_result_mem_in,
    input  logic [DATA_W-1:0] write_data_mem_in,
    input  logic [REG_W-1:0]  write_register_mem_in,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_reg,
    input  logic              reg_write,
    input  logic              flush_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] read_data_write_back_out,
    output logic [DATA_W-1:0] alu_result_write_back_out,
    output logic [REG_W-1:0]  write_register_write_back_out,
    output logic              mem_reg_out,
    output logic              reg_write_out,
    output logic              valid_wb_out
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [REG_W-1:0]    req_dest_q, req_dest_d;
    logic                req_load_q, req_load_d;
    logic                req_mem_reg_q, req_mem_reg_d;
    logic                req_reg_write_q, req_reg_write_d;
    logic                killed_q, killed_d;

    logic                wb_load;
    logic                wb_bubble;
    logic [DATA_W-1:0]   wb_read_data;
    logic [DATA_W-1:0]   wb_alu_result;
    logic [REG_W-1:0]    wb_dest;
    logic                wb_mem_reg;
    logic                wb_reg_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_dest_q      <= '0;
            req_load_q      <= 1'b0;
            req_mem_reg_q   <= 1'b0;
            req_reg_write_q <= 1'b0;
            killed_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_dest_q      <= req_dest_d;
            req_load_q      <= req_load_d;
            req_mem_reg_q   <= req_mem_reg_d;
            req_reg_write_q <= req_reg_write_d;
            killed_q        <= killed_d;
        end
    end

    // Next-state, request capture and MEM/WB payload selection.
    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_dest_d      = req_dest_q;
        req_load_d      = req_load_q;
        req_mem_reg_d   = req_mem_reg_q;
        req_reg_write_d = req_reg_write_q;
        killed_d        = killed_q;
        wb_load         = 1'b0;
        wb_bubble       = 1'b1;
        wb_read_data    = '0;
        wb_alu_result   = '0;
        wb_dest         = '0;
        wb_mem_reg      = 1'b0;
        wb_reg_write    = 1'b0;

        case (state_q)
            IDLE: begin
                wb_load = 1'b1;
                if (valid_mem_in && !flush_in) begin
                    if (mem_read || mem_write) begin
                        state_d         = WAIT_ACK;
                        req_addr_d      = alu_result_mem_in;
                        req_wdata_d     = write_data_mem_in;
                        req_dest_d      = write_register_mem_in;
                        req_load_d      = mem_read;
                        req_mem_reg_d   = mem_reg;
                        req_reg_write_d = reg_write;
                        killed_d        = 1'b0;
                    end else begin
                        wb_bubble     = 1'b0;
                        wb_alu_result = alu_result_mem_in;
                        wb_dest       = write_register_mem_in;
                        wb_mem_reg    = mem_reg;
                        wb_reg_write  = reg_write;
                    end
                end
            end
            WAIT_ACK: begin
                if (flush_in) begin
                    killed_d = 1'b1;
                end
                // A flush on the ack cycle itself also kills the completion.
                if (mem_ack) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                    wb_load  = 1'b1;
                    if (!(killed_q || flush_in)) begin
                        wb_bubble     = 1'b0;
                        wb_read_data  = req_load_q ? mem_rdata : '0;
                        wb_alu_result = req_addr_q;
                        wb_dest       = req_dest_q;
                        wb_mem_reg    = req_mem_reg_q;
                        wb_reg_write  = req_reg_write_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_out = (state_q == WAIT_ACK);
    assign mem_req   = stall_out;
    assign mem_we    = stall_out && !req_load_q;
    assign mem_addr  = stall_out ? req_addr_q  : '0;
    assign mem_wdata = stall_out ? req_wdata_q : '0;

    mem_wb_register #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb (
        .clk              (clk),
        .rst              (rst),
        .load_en          (wb_load),
        .bubble           (wb_bubble),
        .read_data_d      (wb_read_data),
        .alu_result_d     (wb_alu_result),
        .write_register_d (wb_dest),
        .mem_reg_d        (wb_mem_reg),
        .reg_write_d      (wb_reg_write),
        .read_data_q      (read_data_write_back_out),
        .alu_result_q     (alu_result_write_back_out),
        .write_register_q (write_register_write_back_out),
        .mem_reg_q        (mem_reg_out),
        .reg_write_q      (reg_write_out),
        .valid_q          (valid_wb_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: vector table for single-cycle
// ops plus hand sequences for memory handshakes, flush and reset.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_mem_in;
    logic [21:0] alu_result_mem_in;
    logic [21:0] write_data_mem_in;
    logic [3:0]  write_register_mem_in;
    logic        mem_read, mem_write, mem_reg, reg_write;
    logic        flush_in;
    logic        stall_out;
    logic        mem_req, mem_we;
    logic [21:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [21:0] read_data_write_back_out, alu_result_write_back_out;
    logic [3:0]  write_register_write_back_out;
    logic        mem_reg_out, reg_write_out, valid_wb_out;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk                           (clk),
        .rst                           (rst),
        .valid_mem_in                  (valid_mem_in),
        .alu_result_mem_in             (alu_result_mem_in),
        .write_data_mem_in             (write_data_mem_in),
        .write_register_mem_in         (write_register_mem_in),
        .mem_read                      (mem_read),
        .mem_write                     (mem_write),
        .mem_reg                       (mem_reg),
        .reg_write                     (reg_write),
        .flush_in                      (flush_in),
        .stall_out                     (stall_out),
        .mem_req                       (mem_req),
        .mem_we                        (mem_we),
        .mem_addr                      (mem_addr),
        .mem_wdata                     (mem_wdata),
        .mem_rdata                     (mem_rdata),
        .mem_ack                       (mem_ack),
        .read_data_write_back_out      (read_data_write_back_out),
        .alu_result_write_back_out     (alu_result_write_back_out),
        .write_register_write_back_out (write_register_write_back_out),
        .mem_reg_out                   (mem_reg_out),
        .reg_write_out                 (reg_write_out),
        .valid_wb_out                  (valid_wb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, fl, mr, rw;
        logic [21:0] alu;
        logic [3:0]  dest;
        logic        e_valid, e_mr, e_rw;
        logic [21:0] e_alu;
        logic [3:0]  e_dest;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic fl,
                         input logic [21:0] alu, input logic [21:0] wd, input logic [3:0] dest,
                         input logic mr, input logic rw);
        valid_mem_in          = v;
        mem_read              = rd;
        mem_write             = wr;
        flush_in              = fl;
        alu_result_mem_in     = alu;
        write_data_mem_in     = wd;
        write_register_mem_in = dest;
        mem_reg               = mr;
        reg_write             = rw;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(valid_wb_out), 32'd0);
        chk({tag, "_regw"},  32'(reg_write_out), 32'd0);
        chk({tag, "_rdata"}, 32'(read_data_write_back_out), 32'd0);
        chk({tag, "_alu"},   32'(alu_result_write_back_out), 32'd0);
    endtask

    // A write-back register write must never be visible without a valid slot.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (reg_write_out && !valid_wb_out) begin
                errors++;
                $display("FAIL regw_without_valid actual=1 required=0");
            end
        end
    end

    int stall_cnt;
    int req_cnt;

    initial begin
        rst = 1'b1;
        mem_rdata = '0;
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        #1;
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk_bubble("rst");
        tick();
        tick();
        rst = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 22'h00012, 4'h3, 1'b1, 1'b0, 1'b1, 22'h00012, 4'h3};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 22'h3FFFFF, 4'hF, 1'b1, 1'b1, 1'b1, 22'h3FFFFF, 4'hF};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 22'h00055, 4'h5, 1'b0, 1'b0, 1'b0, 22'h0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 22'h00077, 4'h7, 1'b0, 1'b0, 1'b0, 22'h0, 4'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 22'h2AAAA, 4'hA, 1'b1, 1'b0, 1'b0, 22'h2AAAA, 4'hA};

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].v, 0, 0, vecs[i].fl, vecs[i].alu, 22'h1234, vecs[i].dest,
                  vecs[i].mr, vecs[i].rw);
            mem_ack = (i == 2);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(valid_wb_out), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_alu", i),   32'(alu_result_write_back_out), 32'(vecs[i].e_alu));
            chk($sformatf("vec%0d_dest", i),  32'(write_register_write_back_out), 32'(vecs[i].e_dest));
            chk($sformatf("vec%0d_mr", i),    32'(mem_reg_out), 32'(vecs[i].e_mr));
            chk($sformatf("vec%0d_rw", i),    32'(reg_write_out), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d_rdata", i), 32'(read_data_write_back_out), 32'd0);
            chk($sformatf("vec%0d_stall", i), 32'(stall_out), 32'd0);
            chk($sformatf("vec%0d_req", i),   32'(mem_req), 32'd0);
            chk($sformatf("vec%0d_addr", i),  32'(mem_addr), 32'd0);
        end
        mem_ack = 1'b0;

        // Load, ack on the third WAIT_ACK cycle.
        drive(1, 1, 0, 0, 22'h00040, 22'h0, 4'h5, 1, 1);
        stall_cnt = 0;
        req_cnt = 0;
        tick();
        chk("ld_entry_bubble", 32'(valid_wb_out), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            if (stall_out) stall_cnt++;
            if (mem_req) req_cnt++;
            chk($sformatf("ld_addr_c%0d", c), 32'(mem_addr), 32'h40);
            chk($sformatf("ld_we_c%0d", c), 32'(mem_we), 32'd0);
            chk($sformatf("ld_hold_c%0d", c), 32'(valid_wb_out), 32'd0);
            if (c == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 22'h3ABCD;
            end
            tick();
        end
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        chk("ld_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("ld_req_cycles",   32'(req_cnt), 32'd3);
        chk("ld_rdata", 32'(read_data_write_back_out), 32'h3ABCD);
        chk("ld_mr",    32'(mem_reg_out), 32'd1);
        chk("ld_valid", 32'(valid_wb_out), 32'd1);
        chk("ld_rw",    32'(reg_write_out), 32'd1);
        chk("ld_dest",  32'(write_register_write_back_out), 32'h5);
        chk("ld_done_stall", 32'(stall_out), 32'd0);
        chk("ld_done_req",   32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_ignored", 32'(valid_wb_out), 32'd0);
        chk("idle_ack_stall",   32'(stall_out), 32'd0);

        // Store, ack on the first WAIT_ACK cycle; rdata must not leak through.
        drive(1, 0, 1, 0, 22'h00010, 22'h00FF0, 4'h2, 0, 0);
        tick();
        chk("st_req",   32'(mem_req), 32'd1);
        chk("st_we",    32'(mem_we), 32'd1);
        chk("st_addr",  32'(mem_addr), 32'h10);
        chk("st_wdata", 32'(mem_wdata), 32'hFF0);
        mem_ack = 1'b1;
        mem_rdata = 22'h12345;
        tick();
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        chk("st_valid", 32'(valid_wb_out), 32'd1);
        chk("st_rw",    32'(reg_write_out), 32'd0);
        chk("st_rdata", 32'(read_data_write_back_out), 32'd0);
        chk("st_wdata_idle", 32'(mem_wdata), 32'd0);

        // Read and write together act as a load.
        drive(1, 1, 1, 0, 22'h00020, 22'h00ABC, 4'h4, 1, 1);
        tick();
        chk("rw_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 22'h00777;
        tick();
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        chk("rw_rdata", 32'(read_data_write_back_out), 32'h777);

        // Flush while waiting: request completes, completion is a bubble.
        drive(1, 1, 0, 0, 22'h00050, 22'h0, 4'h6, 1, 1);
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("fl_req_held", 32'(mem_req), 32'd1);
        chk("fl_addr_held", 32'(mem_addr), 32'h50);
        mem_ack = 1'b1;
        mem_rdata = 22'h0BEEF;
        tick();
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        chk_bubble("fl_done");
        chk("fl_idle", 32'(stall_out), 32'd0);

        // Reset mid-request, then a stray ack.
        drive(1, 1, 0, 0, 22'h00060, 22'h0, 4'h8, 1, 1);
        tick();
        chk("rs_wait", 32'(stall_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_stall", 32'(stall_out), 32'd0);
        chk("rs_req",   32'(mem_req), 32'd0);
        chk("rs_addr",  32'(mem_addr), 32'd0);
        chk_bubble("rs");
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 22'h11111;
        tick();
        mem_ack = 1'b0;
        chk("rs_stray_valid", 32'(valid_wb_out), 32'd0);
        chk("rs_stray_stall", 32'(stall_out), 32'd0);

        // Load followed by an ALU op that waits behind the stall.
        drive(1, 1, 0, 0, 22'h00070, 22'h0, 4'h9, 1, 1);
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 22'h2468A;
        tick();
        mem_ack = 1'b0;
        chk("b2b_ld_valid", 32'(valid_wb_out), 32'd1);
        chk("b2b_ld_rdata", 32'(read_data_write_back_out), 32'h2468A);
        chk("b2b_ld_dest",  32'(write_register_write_back_out), 32'h9);
        drive(1, 0, 0, 0, 22'h00123, 22'h0, 4'hB, 0, 1);
        tick();
        drive(0, 0, 0, 0, 22'h0, 22'h0, 4'h0, 0, 0);
        chk("b2b_alu_valid", 32'(valid_wb_out), 32'd1);
        chk("b2b_alu_res",   32'(alu_result_write_back_out), 32'h123);
        chk("b2b_alu_dest",  32'(write_register_write_back_out), 32'hB);
        chk("b2b_alu_rdata", 32'(read_data_write_back_out), 32'd0);
        tick();
        chk("b2b_no_dup", 32'(valid_wb_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
